// File: rtl/spu_pkg.sv
// Shared definitions for the SPU draw engine: op codes, FSM states,
// control-word/operand field positions and clipping helpers.
package spu_pkg;

    localparam logic [3:0] SPU_OP_FILL = 4'b0101;
    localparam logic [3:0] SPU_OP_PLOT = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } draw_state_t;

    localparam int CTRL_OP_MSB    = 11;
    localparam int CTRL_OP_LSB    = 8;
    localparam int CTRL_COLOR_MSB = 7;
    localparam int CTRL_COLOR_LSB = 0;

    // Packed operands: low half is x / width, high half is y / height.
    localparam int OPND_LO_MSB = 15;
    localparam int OPND_LO_LSB = 0;
    localparam int OPND_HI_MSB = 31;
    localparam int OPND_HI_LSB = 16;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == SPU_OP_FILL) || (op == SPU_OP_PLOT);
    endfunction

    function automatic logic [16:0] clip_end(input logic [15:0] origin,
                                             input logic [15:0] extent,
                                             input logic [16:0] limit);
        logic [16:0] sum;
        sum = {1'b0, origin} + {1'b0, extent};
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/spu_raster_counter.sv
// Row-major x/y/address stepper for the draw engine; the only multiply
// happens upstream, here every address is derived incrementally.
module spu_raster_counter #(
    parameter int FB_W   = 320,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [15:0]       x0,
    input  logic [15:0]       y0,
    input  logic [16:0]       x_end,
    input  logic [16:0]       y_end,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [16:0]       x_r;
    logic [16:0]       y_r;
    logic [16:0]       x0_r;
    logic [16:0]       x_end_r;
    logic [16:0]       y_end_r;
    logic [ADDR_W-1:0] row_base_r;
    logic [ADDR_W-1:0] addr_r;
    logic              row_end_s;

    assign row_end_s = ((x_r + 17'd1) == x_end_r);
    assign last      = row_end_s && ((y_r + 17'd1) == y_end_r);
    assign addr      = addr_r;

    // Load the window at setup, then advance one pixel per accepted write;
    // the final pixel does not advance so the address bus stays on it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r        <= 17'd0;
            y_r        <= 17'd0;
            x0_r       <= 17'd0;
            x_end_r    <= 17'd0;
            y_end_r    <= 17'd0;
            row_base_r <= '0;
            addr_r     <= '0;
        end else if (load) begin
            x_r        <= {1'b0, x0};
            y_r        <= {1'b0, y0};
            x0_r       <= {1'b0, x0};
            x_end_r    <= x_end;
            y_end_r    <= y_end;
            row_base_r <= start_addr;
            addr_r     <= start_addr;
        end else if (step && !last) begin
            if (row_end_s) begin
                x_r        <= x0_r;
                y_r        <= y_r + 17'd1;
                row_base_r <= row_base_r + ADDR_W'(FB_W);
                addr_r     <= row_base_r + ADDR_W'(FB_W);
            end else begin
                x_r    <= x_r + 17'd1;
                addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            x_r    <= x_r;
            addr_r <= addr_r;
        end
    end

endmodule

// File: rtl/spu_draw_engine.sv
// Multi-cycle SPU draw executor: accepts one PLOT/FILL command, clips it to
// the frame and streams pixel writes over a valid/ready port.
module spu_draw_engine
    import spu_pkg::*;
#(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [11:0]       spu_ctrl,
    input  logic [31:0]       src_a,
    input  logic [31:0]       src_b,
    output logic              busy,
    output logic              done,
    output logic              cmd_err,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_wdata
);

    localparam logic [16:0] FB_W_L = 17'(FB_W);
    localparam logic [16:0] FB_H_L = 17'(FB_H);

    draw_state_t       state_r;
    logic              cmd_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              cmd_err_r;
    logic              fb_we_r;
    logic [PIX_W-1:0]  fb_wdata_r;
    logic [PIX_W-1:0]  color_r;
    logic              illegal_r;
    logic [15:0]       x0_r;
    logic [15:0]       y0_r;
    logic [15:0]       w_r;
    logic [15:0]       h_r;

    logic [16:0]       x_end_s;
    logic [16:0]       y_end_s;
    logic              empty_s;
    logic [ADDR_W-1:0] start_addr_s;
    logic              load_s;
    logic              step_s;
    logic              last_s;
    logic [ADDR_W-1:0] addr_s;
    logic [3:0]        op_s;

    assign op_s      = spu_ctrl[CTRL_OP_MSB:CTRL_OP_LSB];
    assign load_s    = (state_r == SETUP);
    assign step_s    = (state_r == DRAW) && fb_we_r && fb_ready;

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cmd_err   = cmd_err_r;
    assign fb_we     = fb_we_r;
    assign fb_addr   = addr_s;
    assign fb_wdata  = fb_wdata_r;

    // Clip the captured rectangle against the frame and form the start address.
    always_comb begin
        x_end_s      = clip_end(x0_r, w_r, FB_W_L);
        y_end_s      = clip_end(y0_r, h_r, FB_H_L);
        empty_s      = illegal_r || (w_r == 16'd0) || (h_r == 16'd0) ||
                       ({1'b0, x0_r} >= x_end_s) || ({1'b0, y0_r} >= y_end_s);
        start_addr_s = ADDR_W'(y0_r) * ADDR_W'(FB_W) + ADDR_W'(x0_r);
    end

    spu_raster_counter #(
        .FB_W   (FB_W),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .step       (step_s),
        .x0         (x0_r),
        .y0         (y0_r),
        .x_end      (x_end_s),
        .y_end      (y_end_s),
        .start_addr (start_addr_s),
        .addr       (addr_s),
        .last       (last_s)
    );

    // Command FSM with all handshake and write-port outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cmd_err_r   <= 1'b0;
            fb_we_r     <= 1'b0;
            fb_wdata_r  <= '0;
            color_r     <= '0;
            illegal_r   <= 1'b0;
            x0_r        <= 16'd0;
            y0_r        <= 16'd0;
            w_r         <= 16'd0;
            h_r         <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        state_r     <= SETUP;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        color_r     <= PIX_W'(spu_ctrl[CTRL_COLOR_MSB:CTRL_COLOR_LSB]);
                        illegal_r   <= !op_is_legal(op_s);
                        x0_r        <= src_a[OPND_LO_MSB:OPND_LO_LSB];
                        y0_r        <= src_a[OPND_HI_MSB:OPND_HI_LSB];
                        // PLOT is a 1x1 fill; its extent operand is ignored.
                        if (op_s == SPU_OP_PLOT) begin
                            w_r <= 16'd1;
                            h_r <= 16'd1;
                        end else begin
                            w_r <= src_b[OPND_LO_MSB:OPND_LO_LSB];
                            h_r <= src_b[OPND_HI_MSB:OPND_HI_LSB];
                        end
                    end
                end
                SETUP: begin
                    if (empty_s) begin
                        state_r   <= DONE;
                        done_r    <= 1'b1;
                        cmd_err_r <= illegal_r;
                    end else begin
                        state_r    <= DRAW;
                        fb_we_r    <= 1'b1;
                        fb_wdata_r <= color_r;
                    end
                end
                DRAW: begin
                    if (fb_ready && last_s) begin
                        state_r <= DONE;
                        fb_we_r <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    done_r      <= 1'b0;
                    cmd_err_r   <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    cmd_err_r   <= 1'b0;
                    fb_we_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spu_draw_engine.sv
// Self-checking bench for spu_draw_engine: directed scenarios plus random
// commands compared against a rectangle-enumerating reference model.
module tb_spu_draw_engine;

    localparam int FB_W   = 320;
    localparam int FB_H   = 240;
    localparam int ADDR_W = 17;
    localparam int PIX_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [11:0]       spu_ctrl;
    logic [31:0]       src_a;
    logic [31:0]       src_b;
    logic              busy;
    logic              done;
    logic              cmd_err;
    logic              fb_we;
    logic              fb_ready;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_wdata;

    int errors = 0;
    int checks = 0;

    // Observations of one command execution.
    int   wr_addr[$];
    int   wr_data[$];
    int   wr_cyc[$];
    int   done_cyc;
    logic err_at_done;
    logic busy_at_done;
    logic ready_after;
    int   hold_viol;
    int   stray_err;
    bit   timed_out;

    // Reference expectation.
    int exp_addr[$];
    bit exp_err;

    spu_draw_engine #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .spu_ctrl(spu_ctrl), .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .cmd_err(cmd_err), .fb_we(fb_we), .fb_ready(fb_ready), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata)
    );

    always #5 clk = ~clk;

    task automatic build_expect(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int x0, y0, w, h;
        exp_addr.delete();
        x0 = int'(a[15:0]);
        y0 = int'(a[31:16]);
        w  = int'(b[15:0]);
        h  = int'(b[31:16]);
        exp_err = !(op == 4'b0101 || op == 4'b1100);
        if (op == 4'b1100) begin
            w = 1;
            h = 1;
        end
        if (!exp_err) begin
            for (int y = y0; y < y0 + h && y < FB_H; y++)
                for (int x = x0; x < x0 + w && x < FB_W; x++)
                    exp_addr.push_back(y * FB_W + x);
        end
    endtask

    // Issue one command at the current negedge (cycle 0) and record the writes.
    // mode: 0 = fb_ready always 1, 1 = ready only on odd cycles, 2 = random ready.
    task automatic exec_cmd(input logic [3:0] op, input logic [7:0] color,
                            input logic [31:0] a, input logic [31:0] b, input int mode);
        logic              pend;
        logic [ADDR_W-1:0] paddr;
        logic [PIX_W-1:0]  pdata;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_cyc = -1; hold_viol = 0; stray_err = 0; timed_out = 0; pend = 1'b0;
        paddr = '0; pdata = '0; ready_after = 1'b0;
        spu_ctrl = {op, color}; src_a = a; src_b = b; cmd_valid = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                cmd_valid = 1'b0;
                spu_ctrl  = 12'($urandom);
                src_a     = $urandom;
                src_b     = $urandom;
            end
            if (done_cyc >= 0) begin
                ready_after = cmd_ready;
                fb_ready    = 1'b0;
                return;
            end
            if (pend && (!fb_we || fb_addr !== paddr || fb_wdata !== pdata)) hold_viol++;
            if (mode == 0)      fb_ready = 1'b1;
            else if (mode == 1) fb_ready = (cyc % 2 == 1);
            else                fb_ready = 1'($urandom_range(0, 1));
            if (fb_we && fb_ready) begin
                wr_addr.push_back(int'(fb_addr));
                wr_data.push_back(int'(fb_wdata));
                wr_cyc.push_back(cyc);
            end
            pend  = fb_we && !fb_ready;
            paddr = fb_addr;
            pdata = fb_wdata;
            if (cmd_err && !done) stray_err++;
            if (done) begin
                done_cyc     = cyc;
                err_at_done  = cmd_err;
                busy_at_done = busy;
            end
        end
        timed_out = 1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; fb_ready = 1'b0;
        spu_ctrl = 12'd0; src_a = 32'd0; src_b = 32'd0;
        @(negedge clk); @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL rst_cmd_err: got %b expected 0", cmd_err); end
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rst_fb_we: got %b expected 0", fb_we); end
        checks++; if (fb_addr !== 17'd0) begin errors++; $display("FAIL rst_fb_addr: got %0d expected 0", fb_addr); end
        checks++; if (fb_wdata !== 8'd0) begin errors++; $display("FAIL rst_fb_wdata: got %0d expected 0", fb_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_plot();
        exec_cmd(4'b1100, 8'hA5, {16'd2, 16'd3}, 32'hFFFF_FFFF, 0);
        checks++; if (timed_out || wr_addr.size() != 1) begin errors++; $display("FAIL plot_count: got %0d expected 1 (timeout=%0d)", wr_addr.size(), timed_out); end
        else begin
            checks++; if (wr_addr[0] != 643) begin errors++; $display("FAIL plot_addr: got %0d expected 643", wr_addr[0]); end
            checks++; if (wr_data[0] != 8'hA5) begin errors++; $display("FAIL plot_data: got %h expected a5", wr_data[0]); end
            checks++; if (wr_cyc[0] != 2) begin errors++; $display("FAIL plot_wr_cycle: got %0d expected 2", wr_cyc[0]); end
        end
        checks++; if (done_cyc != 3) begin errors++; $display("FAIL plot_done_cycle: got %0d expected 3", done_cyc); end
        checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL plot_err: got %b expected 0", err_at_done); end
        checks++; if (busy_at_done !== 1'b1) begin errors++; $display("FAIL plot_busy_at_done: got %b expected 1", busy_at_done); end
    endtask

    task automatic test_fill();
        int exp_list[6] = '{330, 331, 332, 650, 651, 652};
        exec_cmd(4'b0101, 8'h10, {16'd1, 16'd10}, {16'd2, 16'd3}, 0);
        checks++; if (timed_out || wr_addr.size() != 6) begin errors++; $display("FAIL fill_count: got %0d expected 6", wr_addr.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wr_addr[i] != exp_list[i] || wr_data[i] != 8'h10 || wr_cyc[i] != 2 + i) begin
                    errors++;
                    $display("FAIL fill_pix%0d: got addr=%0d data=%h cyc=%0d expected addr=%0d data=10 cyc=%0d",
                             i, wr_addr[i], wr_data[i], wr_cyc[i], exp_list[i], 2 + i);
                end
            end
        end
        checks++; if (done_cyc != 8) begin errors++; $display("FAIL fill_done_cycle: got %0d expected 8", done_cyc); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL fill_ready_after: got %b expected 1", ready_after); end
    endtask

    task automatic test_backpressure();
        int exp_list[6] = '{330, 331, 332, 650, 651, 652};
        exec_cmd(4'b0101, 8'h10, {16'd1, 16'd10}, {16'd2, 16'd3}, 1);
        checks++; if (timed_out || wr_addr.size() != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", wr_addr.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wr_addr[i] != exp_list[i] || wr_data[i] != 8'h10) begin
                    errors++;
                    $display("FAIL bp_pix%0d: got addr=%0d data=%h expected addr=%0d data=10", i, wr_addr[i], wr_data[i], exp_list[i]);
                end
            end
            checks++; if (done_cyc != wr_cyc[5] + 1) begin errors++; $display("FAIL bp_done_cycle: got %0d expected %0d", done_cyc, wr_cyc[5] + 1); end
        end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d violations expected 0", hold_viol); end
    endtask

    task automatic test_clipping();
        exec_cmd(4'b0101, 8'h77, {16'd239, 16'd318}, {16'd5, 16'd5}, 0);
        checks++; if (timed_out || wr_addr.size() != 2) begin errors++; $display("FAIL clip_count: got %0d expected 2", wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] != 76798 || wr_addr[1] != 76799) begin errors++; $display("FAIL clip_addrs: got %0d,%0d expected 76798,76799", wr_addr[0], wr_addr[1]); end
        end
        checks++; if (done_cyc != 4) begin errors++; $display("FAIL clip_done_cycle: got %0d expected 4", done_cyc); end
        exec_cmd(4'b0101, 8'h77, {16'd5, 16'd5}, {16'd4, 16'd0}, 0);
        checks++; if (wr_addr.size() != 0 || done_cyc != 2) begin errors++; $display("FAIL clip_zero_w: got writes=%0d done=%0d expected writes=0 done=2", wr_addr.size(), done_cyc); end
        exec_cmd(4'b0101, 8'h77, {16'd0, 16'd400}, {16'd3, 16'd3}, 0);
        checks++; if (wr_addr.size() != 0 || done_cyc != 2) begin errors++; $display("FAIL clip_x_outside: got writes=%0d done=%0d expected writes=0 done=2", wr_addr.size(), done_cyc); end
        checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL clip_err: got %b expected 0", err_at_done); end
    endtask

    task automatic test_illegal();
        exec_cmd(4'b0011, 8'h55, {16'd1, 16'd1}, {16'd2, 16'd2}, 0);
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL illegal_writes: got %0d expected 0", wr_addr.size()); end
        checks++; if (done_cyc != 2) begin errors++; $display("FAIL illegal_done_cycle: got %0d expected 2", done_cyc); end
        checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", err_at_done); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL illegal_ready_after: got %b expected 1", ready_after); end
        checks++; if (stray_err != 0) begin errors++; $display("FAIL illegal_stray_err: got %0d expected 0", stray_err); end
    endtask

    task automatic test_back_to_back();
        exec_cmd(4'b1100, 8'h01, {16'd0, 16'd0}, 32'd0, 0);
        exec_cmd(4'b1100, 8'h02, {16'd239, 16'd319}, 32'd0, 0);
        checks++; if (wr_addr.size() != 1 || done_cyc != 3) begin errors++; $display("FAIL b2b_second: got writes=%0d done=%0d expected writes=1 done=3", wr_addr.size(), done_cyc); end
        else begin
            checks++; if (wr_addr[0] != 76799 || wr_data[0] != 2) begin errors++; $display("FAIL b2b_pixel: got addr=%0d data=%0d expected addr=76799 data=2", wr_addr[0], wr_data[0]); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [7:0]  color;
        logic [15:0] x, y, w, h;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            else op = $urandom_range(0, 1) ? 4'b0101 : 4'b1100;
            color = 8'($urandom);
            x = $urandom_range(0, 1) ? 16'($urandom_range(312, 330)) : 16'($urandom_range(0, 12));
            y = $urandom_range(0, 1) ? 16'($urandom_range(233, 245)) : 16'($urandom_range(0, 12));
            w = 16'($urandom_range(0, 6));
            h = 16'($urandom_range(0, 6));
            build_expect(op, {y, x}, {h, w});
            exec_cmd(op, color, {y, x}, {h, w}, 2);
            checks++;
            if (timed_out || wr_addr.size() != exp_addr.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d expected %0d (op=%b x=%0d y=%0d w=%0d h=%0d)",
                         n, wr_addr.size(), exp_addr.size(), op, x, y, w, h);
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    checks++;
                    if (wr_addr[i] != exp_addr[i] || wr_data[i] != int'(color)) begin
                        errors++;
                        $display("FAIL rand%0d_pix%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                                 n, i, wr_addr[i], wr_data[i], exp_addr[i], color);
                    end
                end
                checks++;
                if (done_cyc != ((exp_addr.size() > 0) ? wr_cyc[wr_cyc.size() - 1] + 1 : 2)) begin
                    errors++;
                    $display("FAIL rand%0d_done_cycle: got %0d", n, done_cyc);
                end
            end
            checks++;
            if (err_at_done !== exp_err || stray_err != 0 || hold_viol != 0 || ready_after !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_status: got err=%b stray=%0d hold=%0d ready=%b expected err=%b stray=0 hold=0 ready=1",
                         n, err_at_done, stray_err, hold_viol, ready_after, exp_err);
            end
        end
    endtask

    task automatic test_reset_mid_draw();
        int late_writes;
        spu_ctrl = {4'b0101, 8'h10}; src_a = {16'd1, 16'd10}; src_b = {16'd2, 16'd3};
        fb_ready = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (fb_we !== 1'b1 || fb_addr !== 17'd332) begin errors++; $display("FAIL mid_third_pixel: got we=%b addr=%0d expected we=1 addr=332", fb_we, fb_addr); end
        #1 reset = 1'b1;
        #1;
        checks++; if (fb_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_async_drop: got we=%b busy=%b done=%b expected 0,0,0", fb_we, busy, done); end
        @(negedge clk); reset = 1'b0;
        late_writes = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fb_we || busy || done) late_writes++;
        end
        checks++; if (late_writes != 0) begin errors++; $display("FAIL mid_no_activity: got %0d active cycles expected 0", late_writes); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", cmd_ready); end
        exec_cmd(4'b1100, 8'h3C, {16'd7, 16'd5}, 32'd0, 0);
        checks++; if (wr_addr.size() != 1 || done_cyc != 3) begin errors++; $display("FAIL mid_plot: got writes=%0d done=%0d expected writes=1 done=3", wr_addr.size(), done_cyc); end
        else begin
            checks++; if (wr_addr[0] != 2245 || wr_data[0] != 8'h3C) begin errors++; $display("FAIL mid_plot_pixel: got addr=%0d data=%h expected addr=2245 data=3c", wr_addr[0], wr_data[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_plot();
        test_fill();
        test_backpressure();
        test_clipping();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_draw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
